// File: rtl/ota_trim_cal_if.sv
// Bundles the control pins and the OTA macro connections of the trim calibration sequencer.
// The master side drives requests and the raw comparator; the slave side is the sequencer.
interface ota_trim_cal_if #(
    parameter int TRIM_W   = 5,
    parameter int SETTLE_W = 4
);
    logic                start;
    logic                abort;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                cmp_async;
    logic                ota_en;
    logic                in_short;
    logic [TRIM_W-1:0]   trim;
    logic                busy;
    logic                done;
    logic                cal_err;

    modport master (
        output start, abort, settle_cycles, cmp_async,
        input  ota_en, in_short, trim, busy, done, cal_err
    );

    modport slave (
        input  start, abort, settle_cycles, cmp_async,
        output ota_en, in_short, trim, busy, done, cal_err
    );
endinterface

// File: rtl/ota_trim_cal_ctrl.sv
// Powers up the OTA, shorts its inputs and runs a successive-approximation offset search
// on the trim code using the OTA's own comparator decision; holds the result on trim.
//
// state  | meaning
// IDLE   | OTA off, waiting for start; trim keeps its last value
// WARMUP | OTA enabled and inputs shorted, settling for S+1 cycles
// TRIAL  | current bit forced to 1, comparator settling for S+1 cycles
// EVAL   | current bit takes the synchronized comparator decision
// DONE   | result held, OTA left enabled, cal_err flags a railed code
module ota_trim_cal_ctrl #(
    parameter int TRIM_W      = 5,
    parameter int SETTLE_W    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ota_trim_cal_if.slave bus
);
    localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] TRIM_MID = {1'b1, {(TRIM_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WARMUP, TRIAL, EVAL, DONE
    } state_t;

    state_t               state;
    logic [SETTLE_W-1:0]  settle_lat;
    logic [SETTLE_W-1:0]  cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_dn;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 cmp_s;
    logic [TRIM_W-1:0]    trim_set;
    logic [TRIM_W-1:0]    trim_eval;
    logic [TRIM_W-1:0]    trim_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cmp_async};
        end
    end

    assign cmp_s  = sync_q[SYNC_STAGES-1];
    assign idx_dn = bit_idx - IDX_W'(1);

    // trim_eval resolves the current bit; trim_next additionally raises the next trial bit.
    always_comb begin
        trim_set           = bus.trim;
        trim_set[bit_idx]  = 1'b1;
        trim_eval          = bus.trim;
        trim_eval[bit_idx] = cmp_s;
        trim_next          = trim_eval;
        trim_next[idx_dn]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_lat   <= '0;
            cnt          <= '0;
            bit_idx      <= '0;
            bus.ota_en   <= 1'b0;
            bus.in_short <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.cal_err  <= 1'b0;
            bus.trim     <= TRIM_MID;
        end else if (bus.abort) begin
            state        <= IDLE;
            bus.ota_en   <= 1'b0;
            bus.in_short <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.cal_err  <= 1'b0;
            bus.trim     <= TRIM_MID;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= WARMUP;
                        settle_lat   <= bus.settle_cycles;
                        cnt          <= bus.settle_cycles;
                        bit_idx      <= IDX_W'(TRIM_W - 1);
                        bus.ota_en   <= 1'b1;
                        bus.in_short <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.done     <= 1'b0;
                        bus.cal_err  <= 1'b0;
                        bus.trim     <= '0;
                    end
                end
                WARMUP: begin
                    if (cnt == '0) begin
                        state    <= TRIAL;
                        cnt      <= settle_lat;
                        bus.trim <= trim_set;
                    end else begin
                        cnt <= cnt - SETTLE_W'(1);
                    end
                end
                TRIAL: begin
                    if (cnt == '0) begin
                        state <= EVAL;
                    end else begin
                        cnt <= cnt - SETTLE_W'(1);
                    end
                end
                EVAL: begin
                    if (bit_idx == '0) begin
                        state        <= DONE;
                        bus.trim     <= trim_eval;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.in_short <= 1'b0;
                        bus.cal_err  <= (trim_eval == '0) || (&trim_eval);
                    end else begin
                        state    <= TRIAL;
                        bit_idx  <= idx_dn;
                        cnt      <= settle_lat;
                        bus.trim <= trim_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ota_trim_cal_ctrl.sv
// Randomized and directed checks of the OTA trim calibration sequencer against a
// behavioural comparator and result model.
module tb_ota_trim_cal_ctrl;
    localparam int TRIM_W = 5;
    localparam int MAXC   = (1 << TRIM_W) - 1;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cmp_mode;
    int   target;

    ota_trim_cal_if #(.TRIM_W(TRIM_W), .SETTLE_W(4)) bus ();

    ota_trim_cal_ctrl #(.TRIM_W(TRIM_W), .SETTLE_W(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OTA comparator: 1 while the trial code is not above the offset point
    always @(negedge clk) begin
        case (cmp_mode)
            1:       bus.cmp_async = 1'b1;
            2:       bus.cmp_async = 1'b0;
            default: bus.cmp_async = (int'(bus.trim) <= target);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected final code: largest code the comparator still accepts
    function automatic int exp_code(input int mode, input int tgt);
        if (mode == 1) return MAXC;
        if (mode == 2) return 0;
        return (tgt > MAXC) ? MAXC : tgt;
    endfunction

    function automatic int exp_busy(input int s);
        return (s + 1) + TRIM_W * (s + 2);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ota_en"}, 32'(bus.ota_en), 0);
        chk({tag, "_in_short"}, 32'(bus.in_short), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_cal_err"}, 32'(bus.cal_err), 0);
        chk({tag, "_trim"}, 32'(bus.trim), 32'h10);
    endtask

    task automatic run_cal(input string tag, input int s, input int mode, input int tgt,
                           input int extra_start, input int chg_at, input int chg_val);
        int   cnt;
        logic short_ok;
        int   code;
        @(negedge clk);
        cmp_mode = mode;
        target   = tgt;
        bus.settle_cycles = 4'(s);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        short_ok = 1'b1;
        while (bus.busy && cnt < 300) begin
            if (!bus.in_short || !bus.ota_en) short_ok = 1'b0;
            cnt++;
            bus.start = (cnt == extra_start);
            if (cnt == chg_at) bus.settle_cycles = 4'(chg_val);
            @(negedge clk);
        end
        bus.start = 1'b0;
        code = exp_code(mode, tgt);
        chk({tag, "_busy_len"}, 32'(cnt), 32'(exp_busy(s)));
        chk({tag, "_short_during_busy"}, 32'(short_ok), 1);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_trim"}, 32'(bus.trim), 32'(code));
        chk({tag, "_cal_err"}, 32'(bus.cal_err), 32'((code == 0) || (code == MAXC)));
        chk({tag, "_in_short_done"}, 32'(bus.in_short), 0);
        chk({tag, "_ota_en_done"}, 32'(bus.ota_en), 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cmp_mode = 0;
        target   = 19;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.settle_cycles = 4'd3;
        bus.cmp_async = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        run_cal("t19", 3, 0, 19, -1, -1, 0);
        run_cal("stuck1", 2, 1, 0, -1, -1, 0);
        run_cal("stuck0", 2, 2, 0, -1, -1, 0);

        // abort during the third trial, then recalibrate
        @(negedge clk);
        cmp_mode = 0;
        target = 19;
        bus.settle_cycles = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_pre_busy", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_idle("abort");
        run_cal("after_abort", 3, 0, 19, -1, -1, 0);

        // abort and start together in DONE: abort wins, no restart
        @(negedge clk);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_idle("abort_start");
        @(negedge clk);
        chk("abort_start_no_run", 32'(bus.busy), 0);

        run_cal("start_ignored", 3, 0, 19, 5, -1, 0);

        // asynchronous reset in the middle of the first trial
        @(negedge clk);
        target = 19;
        bus.settle_cycles = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_cal("t7", 3, 0, 7, -1, -1, 0);

        run_cal("pre12", 3, 0, 19, -1, -1, 0);
        run_cal("t12_settle_chg", 3, 0, 12, -1, 4, 5);

        for (int k = 0; k < 10; k++) begin
            int s;
            int mode;
            int tgt;
            s    = int'($urandom_range(2, 7));
            mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            tgt  = int'($urandom_range(0, MAXC));
            run_cal($sformatf("rand%0d", k), s, mode, tgt, -1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
